flp_add_arbiter: RTL and testbench



---
 rtl/flp_arb_pkg.sv | 15 +
 rtl/flp_tag_pipe.sv | 39 +++
 rtl/flp_add_arbiter.sv | 149 ++++++++++++++
 tb/tb_flp_add_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flp_arb_pkg.sv
// Shared constants and the tag bundle for the FLP adder arbiter.
// Ports: none (package). Tag ids are stored at FLP_ID_MAX_W bits (N_REQ <= 16).
package flp_arb_pkg;

    localparam int          FLP_W        = 32;
    localparam int          FLP_ADD_LAT  = 3;
    localparam logic [31:0] FLP_ZERO     = 32'h0;
    localparam int          FLP_ID_MAX_W = 4;

    typedef struct packed {
        logic                    valid;
        logic [FLP_ID_MAX_W-1:0] id;
    } flp_tag_t;

endpackage

// File: rtl/flp_tag_pipe.sv
// Tag shift register matched to the adder latency; only valid bits are reset.
// Ports: clk, rst (async, active-high), i_tag (stage 0 load), o_tag (last stage).
module flp_tag_pipe
    import flp_arb_pkg::*;
#(
    parameter int DEPTH = FLP_ADD_LAT
) (
    input  logic     clk,
    input  logic     rst,
    input  flp_tag_t i_tag,
    output flp_tag_t o_tag
);

    logic [DEPTH-1:0]        r_vld;
    logic [FLP_ID_MAX_W-1:0] r_id [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_tag.valid;
            for (int s = 1; s < DEPTH; s++) begin
                r_vld[s] <= r_vld[s-1];
            end
        end
    end

    // Ids are meaningless while their valid bit is low, so they need no reset.
    always_ff @(posedge clk) begin
        r_id[0] <= i_tag.id;
        for (int s = 1; s < DEPTH; s++) begin
            r_id[s] <= r_id[s-1];
        end
    end

    assign o_tag.valid = r_vld[DEPTH-1];
    assign o_tag.id    = r_id[DEPTH-1];

endmodule

// File: rtl/flp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FLP adder among N_REQ requesters.
// Ports: clk, rst, req_valid/req_ready/req_a/req_b (requesters), add_a/add_b/
// add_sum (adder), resp_valid/resp_id/resp_sum, inflight, busy.
// Option: define FLP_ARB_RESP_REG_EN to register the response outputs (+1 cycle).
module flp_add_arbiter
    import flp_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int ADD_LAT = FLP_ADD_LAT,
    parameter  int ID_W    = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(ADD_LAT + 1) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [FLP_W*N_REQ-1:0] req_a,
    input  logic [FLP_W*N_REQ-1:0] req_b,
    output logic [FLP_W-1:0]       add_a,
    output logic [FLP_W-1:0]       add_b,
    input  logic [FLP_W-1:0]       add_sum,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output logic [FLP_W-1:0]       resp_sum,
    output logic [CNT_W-1:0]       inflight,
    output logic                   busy
);

    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_xfer;
    logic [N_REQ-1:0] w_ready;
    logic [FLP_W-1:0] w_add_a;
    logic [FLP_W-1:0] w_add_b;
    logic [CNT_W-1:0] r_inflight;
    logic [ID_W-1:0]  w_last_id;
    logic             w_ret;
    flp_tag_t         w_tag_in;
    flp_tag_t         w_tag_out;

    // Search from r_rr_ptr upward, wrapping at N_REQ-1.
    always_comb begin
        logic [ID_W:0] cand;
        w_xfer    = 1'b0;
        w_gnt_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!w_xfer && req_valid[cand[ID_W-1:0]]) begin
                w_xfer    = 1'b1;
                w_gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_xfer) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    // One-hot OR mux; zero when nothing is granted.
    always_comb begin
        w_add_a = FLP_ZERO;
        w_add_b = FLP_ZERO;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_ready[i]) begin
                w_add_a = req_a[i*FLP_W +: FLP_W];
                w_add_b = req_b[i*FLP_W +: FLP_W];
            end
        end
    end

    assign req_ready = w_ready;
    assign add_a     = w_add_a;
    assign add_b     = w_add_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            if (w_gnt_idx == ID_W'(N_REQ - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_gnt_idx + ID_W'(1);
            end
        end
    end

    assign w_tag_in.valid = w_xfer;
    assign w_tag_in.id    = FLP_ID_MAX_W'(w_gnt_idx);

    flp_tag_pipe #(
        .DEPTH (ADD_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // An op leaves the adder when its tag reaches the last stage.
    assign w_ret     = w_tag_out.valid;
    assign w_last_id = w_tag_out.valid ? ID_W'(w_tag_out.id) : '0;

`ifdef FLP_ARB_RESP_REG_EN
    logic             r_resp_valid;
    logic [ID_W-1:0]  r_resp_id;
    logic [FLP_W-1:0] r_resp_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_sum   <= FLP_ZERO;
        end else begin
            r_resp_valid <= w_ret;
            r_resp_id    <= w_last_id;
            r_resp_sum   <= add_sum;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_sum   = r_resp_sum;
`else
    assign resp_valid = w_ret;
    assign resp_id    = w_last_id;
    assign resp_sum   = add_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else if (w_xfer && !w_ret) begin
            r_inflight <= r_inflight + CNT_W'(1);
        end else if (!w_xfer && w_ret) begin
            r_inflight <= r_inflight - CNT_W'(1);
        end
    end

    assign inflight = r_inflight;
    assign busy     = |r_inflight;

endmodule

// File: tb/tb_flp_add_arbiter.sv
// Testbench for flp_add_arbiter: scenario tasks plus a scoreboard monitor.
// Ports: none. Models the external 3-register adder; honours FLP_ARB_RESP_REG_EN.
module tb_flp_add_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;
`ifdef FLP_ARB_RESP_REG_EN
    localparam int RREG = 1;
`else
    localparam int RREG = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [31:0]   add_a, add_b, add_sum;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [31:0]   resp_sum;
    logic [2:0]    inflight;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          id;
        logic [31:0] sum;
        int          leave;
        int          due;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;
    int   m_inf = 0;

    flp_add_arbiter #(.N_REQ(N), .ADD_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .inflight   (inflight),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3FC00000 && b == 32'h40200000) return 32'h40800000;
        return a + b;
    endfunction

    // External adder: three unreset pipeline registers.
    logic [31:0] s1, s2, s3;
    always @(posedge clk) begin
        s1 <= fadd(add_a, add_b);
        s2 <= s1;
        s3 <= s2;
    end
    assign add_sum = s3;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: model grant, push on transfer, pop/compare on response.
    always @(negedge clk) begin
        int          eg;
        logic [3:0]  e_rdy;
        logic [31:0] e_a, e_b;
        logic        e_rv;
        int          left;
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_inf = 0;
            n_vec++;
            if (resp_valid !== 1'b0 || inflight !== 3'd0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rst_hold: rv=%b infl=%0d busy=%b want 0/0/0",
                         resp_valid, inflight, busy);
            end
        end else begin
            eg = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (eg < 0 && req_valid[j]) eg = j;
            end
            e_rdy = (eg >= 0) ? 4'(1 << eg) : 4'b0;
            e_a   = (eg >= 0) ? req_a[32*eg +: 32] : 32'h0;
            e_b   = (eg >= 0) ? req_b[32*eg +: 32] : 32'h0;
            n_vec++;
            if (req_ready !== e_rdy || add_a !== e_a || add_b !== e_b) begin
                n_err++;
                $display("FAIL grant c%0d: rdy=%b a=%h b=%h want %b %h %h",
                         cyc, req_ready, add_a, add_b, e_rdy, e_a, e_b);
            end
            e_rv = (q.size() > 0) && (q[0].due == cyc);
            n_vec++;
            if (resp_valid !== e_rv) begin
                n_err++;
                $display("FAIL resp_valid c%0d: got %b want %b", cyc, resp_valid, e_rv);
            end else if (e_rv) begin
                n_vec++;
                if (resp_id !== 2'(q[0].id) || resp_sum !== q[0].sum) begin
                    n_err++;
                    $display("FAIL resp_data c%0d: id=%0d sum=%h want %0d %h",
                             cyc, resp_id, resp_sum, q[0].id, q[0].sum);
                end
            end
            n_vec++;
            if (inflight !== 3'(m_inf) || busy !== (m_inf != 0)) begin
                n_err++;
                $display("FAIL inflight c%0d: got %0d busy=%b want %0d",
                         cyc, inflight, busy, m_inf);
            end
            left = 0;
            foreach (q[i]) if (q[i].leave == cyc) left = 1;
            if (e_rv) void'(q.pop_front());
            if (eg >= 0) begin
                q.push_back('{eg, fadd(e_a, e_b), cyc + LAT, cyc + LAT + RREG});
                m_ptr = (eg + 1) % N;
            end
            m_inf = m_inf + ((eg >= 0) ? 1 : 0) - left;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0 || inflight !== 3'd0 ||
            busy !== 1'b0 || req_ready !== 4'b0) begin
            n_err++;
            $display("FAIL reset: rv=%b id=%0d infl=%0d busy=%b rdy=%b want zeros",
                     resp_valid, resp_id, inflight, busy, req_ready);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        step();
        req_valid      = 4'b0001;
        req_a[31:0]    = 32'h3F800000;
        req_b[31:0]    = 32'h40000000;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001 || inflight !== 3'd0) begin
            n_err++;
            $display("FAIL single_grant: rdy=%b infl=%0d want 0001 0", req_ready, inflight);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (inflight !== 3'd1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_infl: infl=%0d rv=%b want 1 0", inflight, resp_valid);
        end
        repeat (LAT + RREG - 1) step();
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 32'h40400000 ||
            inflight !== 3'(1 - RREG)) begin
            n_err++;
            $display("FAIL single_resp: rv=%b id=%0d sum=%h infl=%0d want 1 0 40400000 %0d",
                     resp_valid, resp_id, resp_sum, inflight, 1 - RREG);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || inflight !== 3'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: rv=%b infl=%0d busy=%b want 0 0 0",
                     resp_valid, inflight, busy);
        end
    endtask

    task automatic test_all_valid();
        do_reset();
        step();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'h1000_0000 + 32'(i);
            req_b[32*i +: 32] = 32'(i) << 8;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== 4'(1 << (k % N)) || inflight !== 3'((k < LAT) ? k : LAT)) begin
                n_err++;
                $display("FAIL all_valid k%0d: rdy=%b infl=%0d want %b %0d", k,
                         req_ready, inflight, 4'(1 << (k % N)), (k < LAT) ? k : LAT);
            end
            step();
        end
        req_valid = '0;
        repeat (LAT + 2) step();
    endtask

    task automatic test_sparse();
        step();
        req_a[63:32]   = 32'h3FC00000;
        req_b[63:32]   = 32'h40200000;
        req_a[127:96]  = 32'h00000300;
        req_b[127:96]  = 32'h00000033;
        req_valid      = 4'b0010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL sparse_setup: rdy=%b want 0010", req_ready);
        end
        step();
        req_valid = 4'b1010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL sparse_first: rdy=%b want 1000", req_ready);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL sparse_second: rdy=%b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        repeat (LAT + RREG - 1) step();
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 32'h40800000) begin
            n_err++;
            $display("FAIL sparse_resp: rv=%b id=%0d sum=%h want 1 1 40800000",
                     resp_valid, resp_id, resp_sum);
        end
    endtask

    task automatic test_idle();
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            n_vec++;
            if (add_a !== 32'h0 || add_b !== 32'h0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle k%0d: a=%h b=%h rv=%b busy=%b want 0 0 0 0",
                         k, add_a, add_b, resp_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        step();
        req_a[31:0]  = 32'h00001111;
        req_b[31:0]  = 32'h00002222;
        req_a[95:64] = 32'h00003333;
        req_b[95:64] = 32'h00004444;
        req_valid    = 4'b0101;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_first: rdy=%b want 0100", req_ready);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_second: rdy=%b want 0001", req_ready);
        end
        step();
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (inflight !== 3'd0 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst: infl=%0d rv=%b want 0 0", inflight, resp_valid);
        end
        step();
        rst       = 1'b0;
        req_valid = 4'b1100;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100 || inflight !== 3'd0) begin
            n_err++;
            $display("FAIL mid_regrant: rdy=%b infl=%0d want 0100 0", req_ready, inflight);
        end
        step();
        req_valid = '0;
        repeat (LAT + 3) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_sparse();
        test_idle();
        test_reset_mid();
        @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d responses outstanding want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
